// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED(16,11) decode engine.
package hamming_pkg;

  // Engine sequencing: each word is read (2 bytes), decoded, written (2 bytes).
  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    DECODE,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  // Default memory map and run length.
  localparam int SRC_BASE_DEF  = 64;
  localparam int DST_BASE_DEF  = 94;
  localparam int NUM_WORDS_DEF = 15;

  // Bit positions inside the 16-bit encoded word {hi,lo}.
  localparam int P16_POS = 0;   // overall even parity
  localparam int P1_POS  = 1;
  localparam int P2_POS  = 2;
  localparam int D1_POS  = 3;
  localparam int P4_POS  = 4;
  localparam int D2_POS  = 5;   // d2..d4 occupy [7:5]
  localparam int D4_POS  = 7;
  localparam int P8_POS  = 8;
  localparam int D5_POS  = 9;   // d5..d11 occupy [15:9]
  localparam int D11_POS = 15;

endpackage

// File: rtl/secded_dec16.sv
// Combinational SECDED decoder for one 16-bit Hamming word with overall parity.
// Corrects single errors, flags double errors and returns the 11 data bits.
module secded_dec16
  import hamming_pkg::*;
(
  input  logic [15:0] code_word,
  output logic [10:0] data,
  output logic        single_err,
  output logic        double_err
);

  logic [3:0]  syndrome;
  logic        overall;
  logic [15:0] fixed;
  logic        unused_parity;

  // Syndrome is the XOR of the indices of every set bit above the p16 slot.
  always_comb begin
    syndrome = '0;
    for (int i = 1; i < 16; i++) begin
      if (code_word[i]) begin
        syndrome = syndrome ^ 4'(i);
      end
    end
  end

  assign overall    = ^code_word;
  assign single_err = overall;
  assign double_err = !overall && (syndrome != 4'd0);

  // A single error flips the bit named by the syndrome; syndrome 0 hits only p16.
  assign fixed = overall ? (code_word ^ (16'd1 << syndrome)) : code_word;

  assign data = {fixed[D11_POS:D5_POS], fixed[D4_POS:D2_POS], fixed[D1_POS]};

  // Parity bits of the corrected word carry no payload.
  assign unused_parity = ^{fixed[P8_POS], fixed[P4_POS], fixed[P2_POS],
                           fixed[P1_POS], fixed[P16_POS]};

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-to-memory SECDED decode engine: reads NUM_WORDS encoded words from
// SRC_BASE, writes decoded words to DST_BASE and counts corrected/detected errors.
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int SRC_BASE  = SRC_BASE_DEF,
  parameter int DST_BASE  = DST_BASE_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       ack,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [3:0] single_cnt,
  output logic [3:0] double_cnt
);

  localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
  localparam logic [7:0] DST_B    = 8'(DST_BASE);
  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  state_t      state, state_nxt;
  logic [7:0]  idx;
  logic [7:0]  offset;
  logic [7:0]  lo_byte, hi_byte;
  logic [7:0]  out_lo, out_hi;
  logic [10:0] dec_data;
  logic        dec_single, dec_double;

  assign offset = {idx[6:0], 1'b0};

  secded_dec16 u_dec (
    .code_word  ({hi_byte, lo_byte}),
    .data       (dec_data),
    .single_err (dec_single),
    .double_err (dec_double)
  );

  // State register; reset drops straight back to IDLE, abandoning any write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus memory strobes; address and data stay 0 outside access states.
  always_comb begin
    state_nxt   = state;
    ack         = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_data = 8'd0;
    case (state)
      IDLE:   if (req) state_nxt = RD_LO;
      RD_LO: begin
        mem_addr  = SRC_B + offset;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_addr  = SRC_B + offset + 8'd1;
        state_nxt = DECODE;
      end
      DECODE: state_nxt = WR_LO;
      WR_LO: begin
        mem_addr    = DST_B + offset;
        mem_wr_en   = 1'b1;
        mem_wr_data = out_lo;
        state_nxt   = WR_HI;
      end
      WR_HI: begin
        mem_addr    = DST_B + offset + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = out_hi;
        state_nxt   = (idx < LAST_IDX) ? RD_LO : DONE;
      end
      DONE: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture bytes, register the decoded word, count errors, step the index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= 8'd0;
      lo_byte    <= 8'd0;
      hi_byte    <= 8'd0;
      out_lo     <= 8'd0;
      out_hi     <= 8'd0;
      single_cnt <= 4'd0;
      double_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          idx        <= 8'd0;
          single_cnt <= 4'd0;
          double_cnt <= 4'd0;
        end
        RD_LO: lo_byte <= mem_rd_data;
        RD_HI: hi_byte <= mem_rd_data;
        DECODE: begin
          out_lo <= dec_data[7:0];
          out_hi <= {dec_double, 4'b0000, dec_data[10:8]};
          if (dec_single && single_cnt != 4'hF) single_cnt <= single_cnt + 4'd1;
          if (dec_double && double_cnt != 4'hF) double_cnt <= double_cnt + 4'd1;
        end
        WR_HI: if (idx < LAST_IDX) idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench for hamming_dec_engine: the driver queues expected writes and
// acks from a hand-computed vector table; a negedge monitor pops and compares.
module tb_hamming_dec_engine;

  localparam logic [7:0] SRC = 8'd64;
  localparam logic [7:0] DST = 8'd94;
  localparam int         NW  = 15;

  typedef struct {
    logic [15:0] code;
    logic [7:0]  hi;
    logic [7:0]  lo;
    bit          sgl;
    bit          dbl;
  } vec_t;
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  typedef struct {
    int         cyc;
    logic [3:0] s;
    logic [3:0] d;
  } ack_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       req   = 1'b0;
  logic       ack, mem_wr_en;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
  logic [3:0] single_cnt, double_cnt;

  logic [7:0] src_mem [256];
  logic [7:0] dst_mem [256];
  logic       fill_dst = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         acks_seen = 0;
  int         base;
  int         k;
  bit         ack_prev = 1'b0;
  vec_t       vtab [10];
  int         sel [NW];
  logic [3:0] exp_s, exp_d;
  wr_t        wr_q [$];
  ack_t       ack_q [$];
  wr_t        mon_w;
  ack_t       mon_a;

  hamming_dec_engine dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .single_cnt  (single_cnt),
    .double_cnt  (double_cnt)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = src_mem[mem_addr];

  // Cycle counter used to time-stamp acks.
  always @(posedge clk) cyc <= cyc + 1;

  // Destination memory: pre-filled with a sentinel, written by the DUT strobe.
  always @(posedge clk) begin
    if (fill_dst) begin
      for (int i = 0; i < 256; i++) dst_mem[i] <= 8'hA5;
    end else if (mem_wr_en) begin
      dst_mem[mem_addr] <= mem_wr_data;
    end
  end

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe and every ack pops one scoreboard entry.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr_en) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_write: addr=%0h data=%0h required=no write", mem_addr, mem_wr_data);
        end else begin
          mon_w = wr_q.pop_front();
          check_output("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
          check_output("wr_data", 32'(mem_wr_data), 32'(mon_w.data));
        end
      end
      if (ack_prev) check_output("ack_width", 32'(ack), 32'd0);
      if (ack) begin
        acks_seen++;
        if (ack_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_ack: cycle=%0d required=no ack", cyc);
        end else begin
          mon_a = ack_q.pop_front();
          check_output("ack_cycle", 32'(cyc), 32'(mon_a.cyc));
          check_output("ack_single_cnt", 32'(single_cnt), 32'(mon_a.s));
          check_output("ack_double_cnt", 32'(double_cnt), 32'(mon_a.d));
        end
      end
      ack_prev = ack;
    end else begin
      ack_prev = 1'b0;
    end
  end

  task automatic check_idle(input string nm);
    check_output({nm, "_ack"},         32'(ack),         32'd0);
    check_output({nm, "_mem_wr_en"},   32'(mem_wr_en),   32'd0);
    check_output({nm, "_mem_addr"},    32'(mem_addr),    32'd0);
    check_output({nm, "_mem_wr_data"}, 32'(mem_wr_data), 32'd0);
    check_output({nm, "_single_cnt"},  32'(single_cnt),  32'd0);
    check_output({nm, "_double_cnt"},  32'(double_cnt),  32'd0);
  endtask

  // Load source words chosen by sel[], sum expected counts, refill destination sentinel.
  task automatic load_mem();
    logic [7:0] a;
    exp_s = 4'd0;
    exp_d = 4'd0;
    for (int i = 0; i < NW; i++) begin
      a = SRC + 8'(2 * i);
      src_mem[a]        = vtab[sel[i]].code[7:0];
      src_mem[a + 8'd1] = vtab[sel[i]].code[15:8];
      if (vtab[sel[i]].sgl && exp_s != 4'hF) exp_s = exp_s + 4'd1;
      if (vtab[sel[i]].dbl && exp_d != 4'hF) exp_d = exp_d + 4'd1;
    end
    @(negedge clk);
    fill_dst = 1'b1;
    @(negedge clk);
    fill_dst = 1'b0;
  endtask

  task automatic push_writes(input int n_full, input bit extra_lo);
    logic [7:0] a;
    for (int i = 0; i < n_full; i++) begin
      a = DST + 8'(2 * i);
      wr_q.push_back('{a, vtab[sel[i]].lo});
      wr_q.push_back('{a + 8'd1, vtab[sel[i]].hi});
    end
    if (extra_lo) begin
      a = DST + 8'(2 * n_full);
      wr_q.push_back('{a, vtab[sel[n_full]].lo});
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    req = 1'b1;
    ack_q.push_back('{cyc + 5 * NW + 1, exp_s, exp_d});
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_acks(input int target, input string nm);
    int c;
    c = 0;
    while (acks_seen < target && c < 400) begin
      @(negedge clk);
      c++;
    end
    check_output({nm, "_ack_seen"}, 32'(acks_seen >= target), 32'd1);
  endtask

  task automatic drain_check(input string nm);
    check_output({nm, "_writes_left"}, 32'(wr_q.size()), 32'd0);
    check_output({nm, "_acks_left"},   32'(ack_q.size()), 32'd0);
    wr_q.delete();
    ack_q.delete();
  endtask

  task automatic finish_run(input string nm);
    repeat (5) @(negedge clk);
    check_output({nm, "_hold_single"}, 32'(single_cnt), 32'(exp_s));
    check_output({nm, "_hold_double"}, 32'(double_cnt), 32'(exp_d));
    check_output({nm, "_idle_addr"},   32'(mem_addr),   32'd0);
    drain_check(nm);
  endtask

  task automatic run_normal(input string nm);
    load_mem();
    push_writes(NW, 1'b0);
    base = acks_seen;
    apply_stimulus();
    wait_acks(base + 1, nm);
    finish_run(nm);
  endtask

  initial begin
    vtab[0] = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b0};
    vtab[1] = '{16'hFFFF, 8'h07, 8'hFF, 1'b0, 1'b0};
    vtab[2] = '{16'h0020, 8'h00, 8'h00, 1'b1, 1'b0};
    vtab[3] = '{16'h0001, 8'h00, 8'h00, 1'b1, 1'b0};
    vtab[4] = '{16'h0006, 8'h80, 8'h00, 1'b0, 1'b1};
    vtab[5] = '{16'h000F, 8'h00, 8'h01, 1'b0, 1'b0};
    vtab[6] = '{16'h020F, 8'h00, 8'h01, 1'b1, 1'b0};
    vtab[7] = '{16'h8117, 8'h04, 8'h00, 1'b0, 1'b0};
    vtab[8] = '{16'h011F, 8'h80, 8'h01, 1'b0, 1'b1};
    vtab[9] = '{16'h7FFF, 8'h07, 8'hFF, 1'b1, 1'b0};
    for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NW; i++) sel[i] = 0;
    run_normal("zeros");

    for (int i = 0; i < NW; i++) sel[i] = i % 10;
    run_normal("mixed");

    for (int i = 0; i < NW; i++) sel[i] = 9;
    run_normal("all_single");

    for (int i = 0; i < NW; i++) sel[i] = (i < 7) ? 4 : 8;
    run_normal("all_double");

    // Abort in cycle 20 (WR_HI of word 3): only words 0..2 and word 3 low byte land.
    for (int i = 0; i < NW; i++) sel[i] = 0;
    sel[0] = 2;
    sel[3] = 1;
    load_mem();
    push_writes(3, 1'b1);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_idle("abort");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_output("abort_word2_hi", 32'(dst_mem[DST + 8'd5]), 32'h00);
    check_output("abort_word3_lo", 32'(dst_mem[DST + 8'd6]), 32'hFF);
    check_output("abort_word3_hi", 32'(dst_mem[DST + 8'd7]), 32'hA5);
    drain_check("abort");

    for (int i = 0; i < NW; i++) sel[i] = 9 - (i % 10);
    run_normal("post_reset");

    // Extra req pulse in the middle of a run must not restart it.
    for (int i = 0; i < NW; i++) sel[i] = (i * 3) % 10;
    load_mem();
    push_writes(NW, 1'b0);
    base = acks_seen;
    apply_stimulus();
    repeat (30) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_acks(base + 1, "pulse");
    repeat (85) @(negedge clk);
    finish_run("pulse");

    // req held high: second run starts one cycle after DONE.
    for (int i = 0; i < NW; i++) sel[i] = (i + 4) % 10;
    load_mem();
    push_writes(NW, 1'b0);
    push_writes(NW, 1'b0);
    base = acks_seen;
    @(negedge clk);
    req = 1'b1;
    k = cyc;
    ack_q.push_back('{k + 76, exp_s, exp_d});
    ack_q.push_back('{k + 153, exp_s, exp_d});
    wait_acks(base + 2, "restart");
    req = 1'b0;
    finish_run("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_dec_engine.md
HAMMING_DEC_ENGINE -- requirements
Module: hamming_dec_engine

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
 SRC_BASE, 64, byte address of first encoded word (low byte).
 DST_BASE, 94, byte address of first decoded word (low byte).
 NUM_WORDS, 15, words processed per request.
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
 clk  input  1  single clock; all state on rising edge.
 reset  input  1  asynchronous, active-low reset.
 req  input  1  start request, sampled in IDLE.
 ack  output  1  one-cycle done pulse.
 mem_addr  output  8  data-memory byte address.
 mem_rd_data  input  8  memory read data, combinational from mem_addr.
 mem_wr_en  output  1  memory write strobe; memory writes on the rising edge.
 mem_wr_data  output  8  memory write data.
 single_cnt  output  4  words with a corrected single error in the last run.
 double_cnt  output  4  words with a detected double error in the last run.

Function
REQ-003 Encoded word layout SHALL be: {hi,lo}[15:9]=d11..d5, [8]=p8, [7:5]=d4..d2, [4]=p4, [3]=d1, [2]=p2, [1]=p1, [0]=p16 (overall even parity).
REQ-004 Syndrome SHALL be s[3:0] = XOR of the bit indices of all set bits in [15:1]; the overall parity bit SHALL be op = XOR of [15:0].
REQ-005 Decode rules: s=0,op=0 -> no error; op=1 -> single error, flip bit s (s=0 means p16 flipped, data untouched); s!=0,op=0 -> double error, data uncorrected.
REQ-006 Output word SHALL be hi={dbl,4'b0,d11..d9}, lo=d8..d1; dbl=1 only for a double error.
REQ-007 FSM states SHALL be IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE.
REQ-008 Transitions:
 IDLE->RD_LO on req=1, clears counters and the word index.
 RD_LO->RD_HI->DECODE->WR_LO->WR_HI unconditionally.
 WR_HI->RD_LO if the index is below NUM_WORDS-1, else DONE.
 DONE->IDLE.
REQ-009 Addressing: RD_LO=SRC_BASE+2i, RD_HI=SRC_BASE+2i+1, WR_LO=DST_BASE+2i, WR_HI=DST_BASE+2i+1; 8-bit modular arithmetic.
REQ-010 mem_wr_en SHALL be 1 only in WR_LO and WR_HI.
REQ-011 Each word SHALL take exactly 5 cycles; ack SHALL assert in the cycle 5*NUM_WORDS+1 after the req-sampling edge (76 at default) and last one cycle.
REQ-012 req SHALL be ignored outside IDLE; req held high SHALL restart a run one cycle after DONE.
REQ-013 single_cnt and double_cnt SHALL increment in DECODE, saturate at 15, and hold their value from DONE until the next accepted req.
REQ-014 In idle states, mem_addr and mem_wr_data SHALL be 0.

Reset
REQ-015 When reset=0, the FSM SHALL go to IDLE immediately and ack, mem_wr_en, mem_addr, mem_wr_data, single_cnt, double_cnt and the index SHALL be 0.
REQ-016 Reset mid-run SHALL abort without completing pending writes; bytes already written stay; ack SHALL not assert.

Structure
REQ-017 Package hamming_pkg SHALL hold the state enum, SRC_BASE/DST_BASE/NUM_WORDS defaults and the bit-position constants of REQ-003.
REQ-018 A combinational sub-module secded_dec16 (16-bit in; 11-bit data, single, double out) SHALL implement REQ-004..006 and SHALL be reusable by a future encoder check.

Verification
REQ-019 All 15 words 16'h0000 -> every output word 16'h0000, both counts 0, ack at cycle 76.
REQ-020 Word 16'hFFFF (d=11'h7FF) -> hi 8'h07, lo 8'hFF, no error counted.
REQ-021 16'h0020 (bit 5 flipped) -> 16'h0000, single_cnt=1; 16'h0001 (p16 flipped) -> 16'h0000, single_cnt increments.
REQ-022 16'h0006 (bits 1 and 2 flipped) -> hi[7]=1 (hi 8'h80), double_cnt=1.
REQ-023 Reset asserted at cycle 20 -> immediate IDLE, outputs 0, no ack; a new req completes a full run normally.
REQ-024 req pulsed during a run -> ignored; a single ack only.
